// File: rtl/fm_sw_ram_dec_multi.sv
// Multi-channel bus address decoder with a registered access sequencer.
// A strobe in IDLE latches the address and direction. The address is matched
// against NUM_CH power-of-two windows, with the lowest index winning. A hit
// drives a one-hot chip select for WAIT_CYCLES+1 cycles and then pulses Ack_OUT.
// A miss pulses Err_OUT.
//
// Ports:
//   Clock      rising-edge clock
//   Reset      asynchronous active-high reset
//   Addr_IN    bus address, sampled on an accepted strobe
//   Strobe_IN  access request, accepted only while Busy_OUT is low
//   Write_IN   1 = write, 0 = read, sampled with Addr_IN
//   CS_OUT     registered one-hot chip select
//   WR_OUT     registered direction, valid while CS_OUT is non-zero
//   Ack_OUT    one-cycle pulse when an access completes
//   Err_OUT    one-cycle pulse when the address matches no window
//   Busy_OUT   high from the cycle after acceptance until the return to IDLE
module fm_sw_ram_dec_multi #(
  parameter int unsigned               ADDR_W       = 13,
  parameter int unsigned               NUM_CH       = 4,
  parameter logic [NUM_CH*ADDR_W-1:0]  CH_BASE      = {13'h1800, 13'h1000, 13'h0000, 13'h1000},
  parameter logic [NUM_CH*5-1:0]       CH_SIZE_LOG2 = {5'd8, 5'd4, 5'd12, 5'd1},
  parameter int unsigned               WAIT_CYCLES  = 2,
  parameter bit                        IGNORE_LSB   = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr_IN,
  input  logic              Strobe_IN,
  input  logic              Write_IN,
  output logic [NUM_CH-1:0] CS_OUT,
  output logic              WR_OUT,
  output logic              Ack_OUT,
  output logic              Err_OUT,
  output logic              Busy_OUT
);

  typedef enum logic [2:0] {StIdle, StDecode, StAccess, StAck, StErr} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [3:0]          cnt_q;
  logic [NUM_CH-1:0]   cs_q;
  logic                wr_q;
  logic                ack_q;
  logic                err_q;
  logic                busy_q;

  logic [NUM_CH-1:0]   sel;
  logic                found;
  logic [ADDR_W-1:0]   addr_in_masked;

  assign addr_in_masked = IGNORE_LSB ? {Addr_IN[ADDR_W-1:1], 1'b0} : Addr_IN;

  // Window match: every bit above the window size must equal the base.
  // Priority goes to the lowest channel index so CS stays one-hot.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found &&
          (((addr_q ^ CH_BASE[i*ADDR_W +: ADDR_W]) >> CH_SIZE_LOG2[i*5 +: 5]) == '0)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      cs_q    <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Strobe_IN) begin
            addr_q  <= addr_in_masked;
            write_q <= Write_IN;
            busy_q  <= 1'b1;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (found) begin
            cs_q    <= sel;
            wr_q    <= write_q;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= StAccess;
          end else begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            // Drop CS and raise Ack together so the pulse follows the last CS cycle.
            cs_q    <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck, StErr: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          cs_q    <= '0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign CS_OUT   = cs_q;
  assign WR_OUT   = wr_q;
  assign Ack_OUT  = ack_q;
  assign Err_OUT  = err_q;
  assign Busy_OUT = busy_q;

endmodule

// File: tb/tb_fm_sw_ram_dec_multi.sv
module tb_fm_sw_ram_dec_multi;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] addr_in;
  logic        write_in;
  logic        stb_a, stb_b;
  logic [3:0]  cs_a, cs_b;
  logic        wr_a, wr_b, ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic        use_b = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Default build: WAIT_CYCLES=2, IGNORE_LSB=1.
  fm_sw_ram_dec_multi dut_a (
    .Clock(clk), .Reset(rst), .Addr_IN(addr_in), .Strobe_IN(stb_a), .Write_IN(write_in),
    .CS_OUT(cs_a), .WR_OUT(wr_a), .Ack_OUT(ack_a), .Err_OUT(err_a), .Busy_OUT(busy_a)
  );

  fm_sw_ram_dec_multi #(.WAIT_CYCLES(0), .IGNORE_LSB(1'b0)) dut_b (
    .Clock(clk), .Reset(rst), .Addr_IN(addr_in), .Strobe_IN(stb_b), .Write_IN(write_in),
    .CS_OUT(cs_b), .WR_OUT(wr_b), .Ack_OUT(ack_b), .Err_OUT(err_b), .Busy_OUT(busy_b)
  );

  logic [3:0] o_cs;
  logic       o_wr, o_ack, o_err, o_busy;
  assign o_cs   = use_b ? cs_b   : cs_a;
  assign o_wr   = use_b ? wr_b   : wr_a;
  assign o_ack  = use_b ? ack_b  : ack_a;
  assign o_err  = use_b ? err_b  : err_a;
  assign o_busy = use_b ? busy_b : busy_a;

  typedef struct {
    int unsigned cs, cs_first, cs_cnt, wr, wr_bad, ack_cnt, ack_last;
    int unsigned err_cnt, err_first, busy_cnt, bad_onehot, overlap;
  } rec_t;

  rec_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_stb(input logic v);
    if (use_b) stb_b = v;
    else stb_a = v;
  endtask

  // Windows written as [base, base + size) ranges, lowest index first.
  function automatic logic [3:0] ref_sel(input logic [12:0] addr, input bit ign);
    int a;
    int base[4];
    int sz[4];
    logic [3:0] r;
    base = '{32'h1000, 32'h0000, 32'h1000, 32'h1800};
    sz   = '{1, 12, 4, 8};
    a = ign ? int'(addr & 13'h1FFE) : int'(addr);
    r = '0;
    for (int i = 0; i < 4; i++)
      if (r == '0 && a >= base[i] && a < base[i] + (1 << sz[i])) r[i] = 1'b1;
    return r;
  endfunction

  // mode 0: single strobe; 1: strobe re-pulsed while busy; 2: strobe held for a second access
  task automatic run_access(input string tag, input logic [12:0] addr, input logic wr,
                            input int mode);
    rec_t e, o;
    int w, n;
    logic [3:0] sel;
    w   = use_b ? W_B : W_A;
    sel = ref_sel(addr, !use_b);
    n   = (mode == 2) ? 2 : 1;
    e = '{default: 0};
    if (sel != 0) begin
      e.cs       = sel;
      e.cs_first = 2;
      e.cs_cnt   = n * (w + 1);
      e.wr       = wr;
      e.ack_cnt  = n;
      e.ack_last = (n == 2) ? 7 + 2 * w : 3 + w;
      e.busy_cnt = n * (3 + w);
    end else begin
      e.err_cnt   = 1;
      e.err_first = 2;
      e.busy_cnt  = 2;
    end
    sb_q.push_back(e);

    o = '{default: 0};
    @(negedge clk);
    chk({tag, "_busy_c0"}, o_busy, 0);
    addr_in  = addr;
    write_in = wr;
    set_stb(1'b1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (o_cs != 0) begin
        o.cs |= o_cs;
        if (o.cs_first == 0) begin
          o.cs_first = c;
          o.wr       = o_wr;
        end
        o.cs_cnt++;
      end else if (o_wr) begin
        o.wr_bad++;
      end
      if (o_ack) begin
        o.ack_cnt++;
        o.ack_last = c;
      end
      if (o_err) begin
        o.err_cnt++;
        if (o.err_first == 0) o.err_first = c;
      end
      if (o_busy) o.busy_cnt++;
      if ($countones(o_cs) > 1) o.bad_onehot++;
      if (o_ack && o_err) o.overlap++;
      // Inputs changed after acceptance must not affect the access in flight.
      if (mode == 2) begin
        set_stb(c <= 4 + w);
        addr_in  = (c == 4 + w) ? addr : ~addr;
        write_in = (c == 4 + w) ? wr : ~wr;
      end else begin
        set_stb(mode == 1 && c <= 3 + w);
        addr_in  = ~addr;
        write_in = ~wr;
      end
    end
    set_stb(1'b0);

    e = sb_q.pop_front();
    chk({tag, "_cs"},        o.cs,         e.cs);
    chk({tag, "_cs_first"},  o.cs_first,   e.cs_first);
    chk({tag, "_cs_cnt"},    o.cs_cnt,     e.cs_cnt);
    chk({tag, "_wr"},        o.wr,         e.wr);
    chk({tag, "_wr_bad"},    o.wr_bad,     e.wr_bad);
    chk({tag, "_ack_cnt"},   o.ack_cnt,    e.ack_cnt);
    chk({tag, "_ack_cyc"},   o.ack_last,   e.ack_last);
    chk({tag, "_err_cnt"},   o.err_cnt,    e.err_cnt);
    chk({tag, "_err_cyc"},   o.err_first,  e.err_first);
    chk({tag, "_busy_cnt"},  o.busy_cnt,   e.busy_cnt);
    chk({tag, "_onehot"},    o.bad_onehot, e.bad_onehot);
    chk({tag, "_ack_err"},   o.overlap,    e.overlap);
  endtask

  task automatic reset_mid_access();
    int acks, errs, css;
    @(negedge clk);
    addr_in  = 13'h0123;
    write_in = 1'b1;
    stb_a    = 1'b1;
    @(negedge clk);
    stb_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_cs_before", cs_a, 4'b0010);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_cs_async", cs_a, 4'b0000);
    chk("rst_mid_busy_async", busy_a, 1'b0);
    chk("rst_mid_wr_async", wr_a, 1'b0);
    acks = 0; errs = 0; css = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) rst = 1'b0;
      if (ack_a) acks++;
      if (err_a) errs++;
      if (cs_a != 0) css++;
    end
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_no_err", errs, 0);
    chk("rst_mid_no_cs", css, 0);
  endtask

  initial begin
    rst      = 1'b1;
    stb_a    = 1'b0;
    stb_b    = 1'b0;
    addr_in  = '0;
    write_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs", cs_a, 4'b0000);
    chk("rst_wr", wr_a, 1'b0);
    chk("rst_ack", ack_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_access("a1001",  13'h1001, 1'b1, 0);
    run_access("a1002",  13'h1002, 1'b0, 0);
    run_access("a1fff",  13'h1fff, 1'b1, 0);
    run_access("repulse", 13'h0123, 1'b0, 1);
    run_access("hold",   13'h0123, 1'b1, 2);
    run_access("a1850",  13'h1850, 1'b1, 0);
    run_access("a0000",  13'h0000, 1'b0, 0);
    run_access("a0fff",  13'h0fff, 1'b1, 0);
    run_access("a100f",  13'h100f, 1'b0, 0);
    run_access("a1010",  13'h1010, 1'b1, 0);
    run_access("a18ff",  13'h18ff, 1'b0, 0);
    run_access("a1900",  13'h1900, 1'b1, 0);
    for (int k = 0; k < 4; k++)
      run_access($sformatf("rnd%0d", k), 13'($urandom_range(0, 8191)), 1'($urandom), 0);

    reset_mid_access();
    run_access("post_rst", 13'h1003, 1'b1, 0);

    use_b = 1'b1;
    run_access("b1001", 13'h1001, 1'b1, 0);
    run_access("b1000", 13'h1000, 1'b0, 0);
    run_access("b1002", 13'h1002, 1'b1, 0);
    run_access("b1fff", 13'h1fff, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fm_sw_ram_dec_multi.md
Name: fm_sw_ram_dec_multi

Overview:
Parametrised, multi-channel bus address decoder with a registered access sequencer. It samples a bus address on a strobe and matches it against NUM_CH power-of-two windows, with A0 optionally ignored. It then drives a one-hot chip select for a programmable number of wait cycles and ends the access with a one-cycle acknowledge, or a one-cycle error if no window matches. It sits between the host bus interface and the waveform RAM / control-register banks of the function generator.

Parameters:
ADDR_W, 13, width of Addr_IN.
NUM_CH, 4, number of decoded windows / chip selects.
CH_BASE, {13'h1800,13'h1000,13'h0000,13'h1000}, packed NUM_CH*ADDR_W base addresses; channel i occupies slice [i*ADDR_W +: ADDR_W].
CH_SIZE_LOG2, {5'd8,5'd4,5'd12,5'd1}, packed NUM_CH*5 window sizes as log2 of bytes; legal range 1..ADDR_W.
WAIT_CYCLES, 2, extra cycles CS is held after the first; legal range 0..15.
IGNORE_LSB, 1, 1 = address bit 0 is forced to 0 before compare.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Addr_IN  input  ADDR_W  bus address, sampled only on accepted strobe.
Strobe_IN  input  1  access request; accepted only when Busy_OUT=0.
Write_IN  input  1  1=write, 0=read; sampled with Addr_IN.
CS_OUT  output  NUM_CH  registered one-hot chip select.
WR_OUT  output  1  registered copy of sampled Write_IN; valid while any CS_OUT bit is high.
Ack_OUT  output  1  one-cycle pulse: access completed.
Err_OUT  output  1  one-cycle pulse: address matched no window.
Busy_OUT  output  1  high from the cycle after acceptance until the return to IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; CS_OUT=0, WR_OUT=0, Ack_OUT=0, Err_OUT=0, Busy_OUT=0; latched address and wait counter cleared. Reset mid-access aborts immediately and no Ack or Err is issued.
- States: IDLE, DECODE, ACCESS, ACK, ERR. All outputs come directly from registers.
- IDLE: if Strobe_IN=1, latch Addr_IN (bit0 cleared if IGNORE_LSB) and Write_IN, then go to DECODE.
- DECODE (1 cycle, Busy=1):
  - Channel i hits when ((addr ^ base_i) >> size_log2_i) == 0.
  - If several channels hit, the lowest index wins; CS is always one-hot.
  - Any hit: load CS_OUT and WR_OUT, counter=WAIT_CYCLES, go to ACCESS.
  - No hit: go to ERR.
- ACCESS: CS_OUT is held. If counter==0, go to ACK; else decrement. CS is high for exactly WAIT_CYCLES+1 cycles.
- ACK (1 cycle): CS_OUT=0, WR_OUT=0, Ack_OUT=1, then IDLE.
- ERR (1 cycle): Err_OUT=1, CS_OUT stays 0, then IDLE.
- Timing, strobe sampled in cycle 0:
  - Hit: CS cycles 2..2+WAIT_CYCLES; Ack in cycle 3+WAIT_CYCLES; next strobe accepted in cycle 4+WAIT_CYCLES.
  - Miss: Err in cycle 2; next strobe accepted in cycle 3.
- Strobe_IN while Busy_OUT=1 is ignored (not queued). Addr_IN and Write_IN changes after acceptance have no effect.
- Strobe held high continuously gives back-to-back accesses, one per IDLE visit.
- Addresses wrap only within ADDR_W; no carry beyond the MSB.
- Ack_OUT and Err_OUT are never high in the same cycle.

Test Plan:
- Reset then Strobe with Addr=0x1001, Write=1 (defaults, IGNORE_LSB=1) -> ch0 hits (0x1000/0x1001 window). CS_OUT=4'b0001 and WR_OUT=1 in cycles 2-4, Ack in cycle 5, Busy in cycles 1-5.
- Addr=0x1002 -> ch0 misses; ch2 (0x1000-0x100F) hits; ch1 window 0x0000-0x0FFF does not contain it. CS_OUT=4'b0100 for 3 cycles, then Ack.
- Addr=0x1FFF -> no window matches (ch3 covers 0x1800-0x18FF) -> no CS, Err_OUT=1 in cycle 2, Ack never asserted, next strobe accepted in cycle 3.
- Strobe re-pulsed in cycles 1-5 of an access to 0x0123 -> only one access occurs: CS_OUT=4'b0010, single Ack. Strobe held high -> second access starts with acceptance in cycle 6.
- Reset asserted asynchronously mid-ACCESS (between clock edges) -> CS_OUT=0 and Busy=0 before the next edge, no Ack. Next strobe after release completes normally.
- Rebuild with WAIT_CYCLES=0, IGNORE_LSB=0, Addr=0x1001 -> ch0 hits (size 2 still covers 0x1001). CS for exactly 1 cycle (cycle 2), Ack in cycle 3.
